// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: show-ahead head, count/full/empty, sticky overflow.
// Define UART_RX_FIFO_DROP_CNT_EN to build the saturating dropped-byte counter.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
    localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          pop_ok, push_ok, drop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CntFull);
    assign pop_ok = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign pop_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CntOne;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CntOne;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'h00;
        end else if (drop) begin
            // A drop coinciding with a clear restarts the count at one.
            if (ovf_clr) begin
                drop_cnt_q <= 8'h01;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'h01;
            end
        end else if (ovf_clr) begin
            drop_cnt_q <= 8'h00;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
